// File: rtl/instruction_fetch_unit.sv
// ============================================================================
//  Module      : instruction_fetch_unit
//  Description : Single-outstanding instruction fetch with a PC-tagged queue
//                feeding decode; flush discards queued and in-flight words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] PcValue,
  output logic                  PcAdvance,
  input  logic                  Flush,
  output logic                  MemReq,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  input  logic                  MemValid,
  input  logic [DATA_WIDTH-1:0] MemData,
  output logic                  InstrValid,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic [ADDR_WIDTH-1:0] InstrPc,
  input  logic                  InstrReady
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_ENT_W = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_PTR_W-1:0]   r_wrPtr;
  logic [c_PTR_W-1:0]   r_rdPtr;
  logic [ADDR_WIDTH-1:0] r_reqPc;
  logic [c_ENT_W-1:0]   r_mem [DEPTH];

  logic w_issue;
  logic w_push;
  logic w_pop;
  logic w_notEmpty;

  assign w_notEmpty = (r_count != '0);

  // Credit check uses registered occupancy only; a same-cycle pop never frees space early.
  always_comb begin
    w_issue = 1'b0;
    if (!Reset && !Flush) begin
      case (r_state)
        S_IDLE:  w_issue = (r_count < c_DEPTH);
        S_WAIT:  w_issue = MemValid && ((r_count + c_ONE) < c_DEPTH);
        default: w_issue = 1'b0;
      endcase
    end
  end

  assign w_push = (r_state == S_WAIT) && MemValid && !Flush;
  assign w_pop  = w_notEmpty && InstrReady && !Flush;

  assign MemReq    = w_issue;
  assign PcAdvance = w_issue;
  assign MemAddr   = w_issue ? PcValue : '0;

  assign InstrValid = w_notEmpty && !Reset;
  assign Instr      = InstrValid ? r_mem[r_rdPtr][DATA_WIDTH-1:0] : '0;
  assign InstrPc    = InstrValid ? r_mem[r_rdPtr][c_ENT_W-1:DATA_WIDTH] : '0;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_reqPc <= '0;
    end else begin
      if (w_issue) begin
        r_reqPc <= PcValue;
      end
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (Flush) begin
            r_state <= MemValid ? S_IDLE : S_DISCARD;
          end else if (MemValid) begin
            r_state <= w_issue ? S_WAIT : S_IDLE;
          end
        end
        S_DISCARD: begin
          // The stale response is the only way out; a repeated flush changes nothing.
          if (MemValid) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (Flush) begin
      r_count <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_ONE;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {r_reqPc, MemData};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
//  Module      : tb_instruction_fetch_unit
//  Description : Directed vector table plus reset and random-latency sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] PcValue;
  logic        PcAdvance;
  logic        Flush;
  logic        MemReq;
  logic [15:0] MemAddr;
  logic        MemValid;
  logic [15:0] MemData;
  logic        InstrValid;
  logic [15:0] Instr;
  logic [15:0] InstrPc;
  logic        InstrReady;

  int nChecks = 0;
  int nFail   = 0;

  always #5 Clock = ~Clock;

  instruction_fetch_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(2)) dut (
    .Clock(Clock), .Reset(Reset), .PcValue(PcValue), .PcAdvance(PcAdvance),
    .Flush(Flush), .MemReq(MemReq), .MemAddr(MemAddr), .MemValid(MemValid),
    .MemData(MemData), .InstrValid(InstrValid), .Instr(Instr), .InstrPc(InstrPc),
    .InstrReady(InstrReady)
  );

  typedef struct {
    logic [15:0] pc;
    logic        flush;
    logic        mv;
    logic [15:0] data;
    logic        rdy;
    logic        expReq;
    logic [15:0] expAddr;
    logic        expIv;
    logic [15:0] expInstr;
    logic [15:0] expIpc;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic vec_t mk(input logic [15:0] pc, input logic flush, input logic mv,
                              input logic [15:0] data, input logic rdy, input logic expReq,
                              input logic [15:0] expAddr, input logic expIv,
                              input logic [15:0] expInstr, input logic [15:0] expIpc);
    vec_t v;
    v.pc = pc; v.flush = flush; v.mv = mv; v.data = data; v.rdy = rdy;
    v.expReq = expReq; v.expAddr = expAddr; v.expIv = expIv;
    v.expInstr = expInstr; v.expIpc = expIpc;
    return v;
  endfunction

  // Random-latency scenario state
  logic        pending;
  int          lat;
  logic [15:0] pendAddr;
  logic [15:0] pcModel;
  logic [15:0] expPop;
  int          pops;

  initial begin
    //          pc       fl   mv   data      rdy  req  addr     iv   instr     ipc
    vecs[0]  = mk(16'h0010,1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0010,1'b0,16'h0000,16'h0000);
    vecs[1]  = mk(16'h0011,1'b0,1'b1,16'hA000,1'b0,1'b1,16'h0011,1'b0,16'h0000,16'h0000);
    vecs[2]  = mk(16'h0012,1'b0,1'b1,16'hA001,1'b0,1'b0,16'h0000,1'b1,16'hA000,16'h0010);
    vecs[3]  = mk(16'h0012,1'b0,1'b1,16'hDEAD,1'b0,1'b0,16'h0000,1'b1,16'hA000,16'h0010);
    vecs[4]  = mk(16'h0012,1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000,1'b1,16'hA000,16'h0010);
    vecs[5]  = mk(16'h0012,1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0012,1'b1,16'hA001,16'h0011);
    vecs[6]  = mk(16'h0013,1'b0,1'b1,16'hA002,1'b1,1'b0,16'h0000,1'b1,16'hA001,16'h0011);
    vecs[7]  = mk(16'h0013,1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000,1'b1,16'hA002,16'h0012);
    vecs[8]  = mk(16'h0100,1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0100,1'b0,16'h0000,16'h0000);
    vecs[9]  = mk(16'h0200,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000);
    vecs[10] = mk(16'h0200,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b0,16'h0000,16'h0000);
    vecs[11] = mk(16'h0200,1'b0,1'b1,16'hBEEF,1'b1,1'b0,16'h0000,1'b0,16'h0000,16'h0000);
    vecs[12] = mk(16'h0200,1'b0,1'b0,16'h0000,1'b1,1'b1,16'h0200,1'b0,16'h0000,16'h0000);
    vecs[13] = mk(16'h0300,1'b1,1'b1,16'hC000,1'b1,1'b0,16'h0000,1'b0,16'h0000,16'h0000);
    vecs[14] = mk(16'h0300,1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0300,1'b0,16'h0000,16'h0000);
    vecs[15] = mk(16'h0301,1'b0,1'b1,16'hC001,1'b0,1'b1,16'h0301,1'b0,16'h0000,16'h0000);
    vecs[16] = mk(16'h0302,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b1,16'hC001,16'h0300);

    Reset = 1'b1; Flush = 1'b0; MemValid = 1'b0; MemData = '0;
    InstrReady = 1'b0; PcValue = 16'h0010;
    #1;
    check("reset_memreq", {31'd0, MemReq}, 32'd0);
    check("reset_pcadv",  {31'd0, PcAdvance}, 32'd0);
    check("reset_memaddr", {16'd0, MemAddr}, 32'd0);
    check("reset_instrvalid", {31'd0, InstrValid}, 32'd0);
    repeat (2) @(posedge Clock);

    // Directed table; row 16 leaves the unit in WAIT with one queued word
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      PcValue = vecs[i].pc; Flush = vecs[i].flush; MemValid = vecs[i].mv;
      MemData = vecs[i].data; InstrReady = vecs[i].rdy;
      #1;
      check($sformatf("v%0d_memreq", i), {31'd0, MemReq}, {31'd0, vecs[i].expReq});
      check($sformatf("v%0d_pcadv", i), {31'd0, PcAdvance}, {31'd0, vecs[i].expReq});
      check($sformatf("v%0d_memaddr", i), {16'd0, MemAddr}, {16'd0, vecs[i].expAddr});
      check($sformatf("v%0d_ivalid", i), {31'd0, InstrValid}, {31'd0, vecs[i].expIv});
      check($sformatf("v%0d_instr", i), {16'd0, Instr}, {16'd0, vecs[i].expInstr});
      check($sformatf("v%0d_instrpc", i), {16'd0, InstrPc}, {16'd0, vecs[i].expIpc});
      @(negedge Clock);
    end

    // Reset asserted mid-WAIT with a word queued and a response arriving
    PcValue = 16'h0040; Flush = 1'b0; MemValid = 1'b1; MemData = 16'h1234; InstrReady = 1'b1;
    Reset = 1'b1;
    #1;
    check("rstwait_memreq", {31'd0, MemReq}, 32'd0);
    check("rstwait_pcadv", {31'd0, PcAdvance}, 32'd0);
    check("rstwait_memaddr", {16'd0, MemAddr}, 32'd0);
    check("rstwait_ivalid", {31'd0, InstrValid}, 32'd0);
    check("rstwait_instr", {16'd0, Instr}, 32'd0);
    check("rstwait_instrpc", {16'd0, InstrPc}, 32'd0);
    @(negedge Clock);
    MemValid = 1'b0; InstrReady = 1'b0;
    Reset = 1'b0;
    #1;
    check("rstrel_memreq", {31'd0, MemReq}, 32'd1);
    check("rstrel_memaddr", {16'd0, MemAddr}, 32'h0040);
    check("rstrel_ivalid", {31'd0, InstrValid}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);

    // Random latency 1..5 and random decode backpressure against a scoreboard
    Reset = 1'b0;
    pending = 1'b0; lat = 0; pendAddr = '0;
    pcModel = 16'h0500; expPop = 16'h0500; pops = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      PcValue = pcModel;
      MemValid = 1'b0; MemData = '0;
      if (pending) begin
        lat--;
        if (lat == 0) begin
          MemValid = 1'b1;
          MemData = memWord(pendAddr);
          pending = 1'b0;
        end
      end
      InstrReady = ($urandom_range(0, 2) != 0);
      #1;
      check("rnd_adv_eq_req", {31'd0, PcAdvance}, {31'd0, MemReq});
      if (MemReq) begin
        check("rnd_single_outstanding", {31'd0, pending}, 32'd0);
        check("rnd_memaddr", {16'd0, MemAddr}, {16'd0, pcModel});
        pending = 1'b1;
        lat = $urandom_range(1, 5);
        pendAddr = MemAddr;
      end
      if (InstrValid && InstrReady) begin
        check("rnd_instrpc", {16'd0, InstrPc}, {16'd0, expPop});
        check("rnd_instr", {16'd0, Instr}, {16'd0, memWord(expPop)});
        expPop = expPop + 16'd1;
        pops++;
      end
      if (PcAdvance) pcModel = pcModel + 16'd1;
      @(negedge Clock);
    end
    check("rnd_progress", {31'd0, (pops > 40)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

`default_nettype wire
